// File: rtl/bus_arbiter_2m.sv
// bus_arbiter_2m: round-robin arbiter
// for two masters on one native bus.
module bus_arbiter_2m #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
`ifdef ARB_TIMEOUT_EN
  output logic        timeout_err,
`endif
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      state;
  logic        last;
  logic        sel_valid;
  logic        fin;
  logic [31:0] rsp_rdata;

  always_comb begin
    sel_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    case (state)
      GNT0: begin
        sel_valid = m0_valid;
        mem_instr = m0_instr;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wstrb = m0_wstrb;
      end
      GNT1: begin
        sel_valid = m1_valid;
        mem_instr = m1_instr;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_wstrb = m1_wstrb;
      end
      default: ;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW =
    (TIMEOUT_CYCLES < 255) ? 8 :
    $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          tout;

  assign tout = sel_valid &&
    (cnt == CW'(TIMEOUT_CYCLES));
  assign fin =
    (sel_valid && mem_ready) || tout;
  assign rsp_rdata =
    tout ? ERR_RDATA : mem_rdata;
  assign mem_valid = sel_valid && !tout;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE)
        cnt <= '0;
      else if (!mem_ready)
        cnt <= cnt + 1'b1;
      if (tout)
        timeout_err <= 1'b1;
    end
  end
`else
  assign fin       = sel_valid && mem_ready;
  assign rsp_rdata = mem_rdata;
  assign mem_valid = sel_valid;
`endif

  assign m0_ready = fin && (state == GNT0);
  assign m1_ready = fin && (state == GNT1);
  assign m0_rdata = m0_ready ? rsp_rdata : '0;
  assign m1_rdata = m1_ready ? rsp_rdata : '0;
  assign grant =
    {state == GNT1, state == GNT0};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid && (!m1_valid || last))
            state <= GNT0;
          else if (m1_valid)
            state <= GNT1;
        end
        default: begin
          if (fin) begin
            state <= IDLE;
            last  <= (state == GNT1);
          end else if (!sel_valid) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// tb_bus_arbiter_2m: vectors, directed
// sequences and a randomized model run.
module tb_bus_arbiter_2m;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m0_instr;
  logic        m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        mem_valid, mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  grant;
`ifdef ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_arbiter_2m #(
    .TIMEOUT_CYCLES(8),
    .ERR_RDATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid),
    .m0_instr(m0_instr),
    .m0_addr(m0_addr),
    .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb),
    .m0_rdata(m0_rdata),
    .m0_ready(m0_ready),
    .m1_valid(m1_valid),
    .m1_instr(m1_instr),
    .m1_addr(m1_addr),
    .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb),
    .m1_rdata(m1_rdata),
    .m1_ready(m1_ready),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
`ifdef ARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .grant(grant)
  );

  typedef struct {
    logic       v0;
    logic       v1;
    logic       rdy;
    logic [1:0] g;
    logic       mv;
    logic       r0;
    logic       r1;
  } vec_t;

  vec_t vt[14];

  task automatic check(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    m0_valid  = 1'b0;
    m1_valid  = 1'b0;
    mem_ready = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_rd;
    int          owner;
    int          lastm;
    int          waitn[2];
    bit          v[2];
    logic [31:0] ra[2];
    logic [31:0] rw[2];
    logic [3:0]  rs[2];
    bit          done;
    logic [1:0]  eg;

    m0_instr = 1'b0;
    m0_addr  = 32'h1000_0000;
    m0_wdata = 32'h1111_1111;
    m0_wstrb = 4'h0;
    m1_instr = 1'b1;
    m1_addr  = 32'h2000_0000;
    m1_wdata = 32'h2222_2222;
    m1_wstrb = 4'hF;
    mem_rdata = 32'h0BAD_F00D;
    do_reset();

    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_mem_valid",
          32'(mem_valid), 32'h0);
    check("rst_mem_instr",
          32'(mem_instr), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb",
          32'(mem_wstrb), 32'h0);
    check("rst_rdy",
          {30'h0, m1_ready, m0_ready}, 32'h0);
    check("rst_rdata",
          m0_rdata | m1_rdata, 32'h0);
`ifdef ARB_TIMEOUT_EN
    check("rst_terr", 32'(timeout_err), 32'h0);
`endif

    vt[0]  = '{1'b1, 1'b1, 1'b0, 2'd0,
               1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b1, 2'd1,
               1'b1, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 2'd0,
               1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b1, 2'd2,
               1'b1, 1'b0, 1'b1};
    vt[4]  = vt[0];
    vt[5]  = vt[1];
    vt[6]  = vt[2];
    vt[7]  = vt[3];
    vt[8]  = '{1'b0, 1'b0, 1'b1, 2'd0,
               1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 2'd0,
               1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 2'd1,
               1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 2'd1,
               1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b0, 2'd0,
               1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b1, 1'b1, 1'b1, 2'd1,
               1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 14; i++) begin
      tick();
      m0_valid  = vt[i].v0;
      m1_valid  = vt[i].v1;
      mem_ready = vt[i].rdy;
      #1;
      check($sformatf("vec%0d_grant", i),
            32'(grant), 32'(vt[i].g));
      check($sformatf("vec%0d_mvalid", i),
            32'(mem_valid), 32'(vt[i].mv));
      check($sformatf("vec%0d_r0", i),
            32'(m0_ready), 32'(vt[i].r0));
      check($sformatf("vec%0d_r1", i),
            32'(m1_ready), 32'(vt[i].r1));
      check($sformatf("vec%0d_rd0", i), m0_rdata,
            vt[i].r0 ? mem_rdata : 32'h0);
      check($sformatf("vec%0d_rd1", i), m1_rdata,
            vt[i].r1 ? mem_rdata : 32'h0);
    end

    do_reset();
    tick();
    m0_valid = 1'b1;
    m0_addr  = 32'h0000_0100;
    m0_wstrb = 4'h0;
    #1;
    check("rd_arb_latency",
          32'(mem_valid), 32'h0);
    tick();
    #1;
    check("rd_mvalid", 32'(mem_valid), 32'h1);
    check("rd_grant", 32'(grant), 32'h1);
    check("rd_addr", mem_addr, 32'h0000_0100);
    check("rd_wait0", 32'(m0_ready), 32'h0);
    tick();
    #1;
    check("rd_wait1", 32'(m0_ready), 32'h0);
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    #1;
    check("rd_ready", 32'(m0_ready), 32'h1);
    check("rd_rdata", m0_rdata, 32'h1234_5678);
    check("rd_m1_quiet", 32'(m1_ready), 32'h0);
    check("rd_m1_rdata", m1_rdata, 32'h0);
    tick();
    m0_valid  = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("rd_idle_grant", 32'(grant), 32'h0);
    check("rd_no_repeat", 32'(m0_ready), 32'h0);

    tick();
    m1_valid = 1'b1;
    m1_instr = 1'b0;
    m1_addr  = 32'hFFFF_0040;
    m1_wdata = 32'hA5A5_A5A5;
    m1_wstrb = 4'b0011;
    tick();
    mem_ready = 1'b1;
    #1;
    check("wr_grant", 32'(grant), 32'h2);
    check("wr_addr", mem_addr, 32'hFFFF_0040);
    check("wr_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("wr_wstrb", 32'(mem_wstrb), 32'h3);
    check("wr_instr", 32'(mem_instr), 32'h0);
    check("wr_ready", 32'(m1_ready), 32'h1);
    check("wr_m0_quiet", 32'(m0_ready), 32'h0);
    tick();
    m1_valid  = 1'b0;
    mem_ready = 1'b0;

    tick();
    m1_valid = 1'b1;
    m1_addr  = 32'h0000_0200;
    tick();
    #1;
    check("mid_grant", 32'(grant), 32'h2);
    resetn = 1'b0;
    tick();
    #1;
    check("mid_mvalid", 32'(mem_valid), 32'h0);
    check("mid_grant_rst", 32'(grant), 32'h0);
    check("mid_no_ready", 32'(m1_ready), 32'h0);
    check("mid_addr", mem_addr, 32'h0);
    resetn   = 1'b1;
    m0_valid = 1'b1;
    tick();
    mem_ready = 1'b1;
    #1;
    check("mid_first_m0", 32'(grant), 32'h1);
    check("mid_m0_ready", 32'(m0_ready), 32'h1);
    tick();
    m0_valid  = 1'b0;
    m1_valid  = 1'b0;
    mem_ready = 1'b0;

`ifdef ARB_TIMEOUT_EN
    do_reset();
    tick();
    m0_valid = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("to_wait%0d", k),
            {30'h0, mem_valid, m0_ready},
            32'h2);
      tick();
    end
    #1;
    check("to_ready", 32'(m0_ready), 32'h1);
    check("to_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("to_mvalid", 32'(mem_valid), 32'h0);
    tick();
    m0_valid = 1'b0;
    m1_valid = 1'b1;
    #1;
    check("to_err", 32'(timeout_err), 32'h1);
    check("to_idle", 32'(grant), 32'h0);
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_CAFE;
    #1;
    check("to_m1_grant", 32'(grant), 32'h2);
    check("to_m1_rdata", m1_rdata,
          32'h0000_CAFE);
    tick();
    m1_valid  = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("to_err_sticky",
          32'(timeout_err), 32'h1);
`endif

    do_reset();
    owner = -1;
    lastm = 1;
    v[0] = 0;
    v[1] = 0;
    waitn[0] = 0;
    waitn[1] = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if (!v[m] &&
            $urandom_range(0, 2) == 0) begin
          v[m]     = 1;
          ra[m]    = $urandom;
          rw[m]    = $urandom;
          rs[m]    = 4'($urandom);
          waitn[m] = 0;
        end
      end
      m0_valid = v[0];
      m0_addr  = ra[0];
      m0_wdata = rw[0];
      m0_wstrb = rs[0];
      m1_valid = v[1];
      m1_addr  = ra[1];
      m1_wdata = rw[1];
      m1_wstrb = rs[1];
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      #1;
      eg = (owner == 0) ? 2'b01 :
           (owner == 1) ? 2'b10 : 2'b00;
      done = (owner >= 0) && v[owner] &&
             mem_ready;
      check("rnd_grant", 32'(grant), 32'(eg));
      check("rnd_mvalid", 32'(mem_valid),
            32'((owner >= 0) && v[owner]));
      if (owner >= 0) begin
        check("rnd_addr", mem_addr, ra[owner]);
        check("rnd_wdata", mem_wdata,
              rw[owner]);
      end
      exp_rd = mem_rdata;
      check("rnd_r0", 32'(m0_ready),
            32'(done && owner == 0));
      check("rnd_r1", 32'(m1_ready),
            32'(done && owner == 1));
      check("rnd_rd0", m0_rdata,
            (done && owner == 0) ?
            exp_rd : 32'h0);
      check("rnd_rd1", m1_rdata,
            (done && owner == 1) ?
            exp_rd : 32'h0);
      if (owner < 0) begin
        if (v[0] && v[1])
          owner = 1 - lastm;
        else if (v[0])
          owner = 0;
        else if (v[1])
          owner = 1;
      end else if (done) begin
        lastm    = owner;
        v[owner] = 0;
        if (v[1 - owner]) begin
          waitn[1 - owner]++;
          check("rnd_fair",
                32'(waitn[1 - owner] <= 1),
                32'h1);
        end
        owner = -1;
      end
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_2m.md
Name: bus_arbiter_2m

Overview:
- Shares the single native memory bus (valid/ready, addr, wdata, wstrb, rdata) between two masters: M0 (CPU) and M1 (DMA or second core).
- Sits upstream of the address-decode/read-mux bus interface, so the downstream decode and peripherals see exactly one master at a time.
- Arbitration is round-robin. A grant is held for exactly one transfer, which ends on the slave's ready pulse.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles a granted transfer may wait for slave ready. Used only when ARB_TIMEOUT_EN is defined.
- ERR_RDATA, 32'hDEADBEEF: read data returned to the master on a timeout. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- m0_valid  in  1  M0 request
- m0_instr  in  1  M0 instruction-fetch flag
- m0_addr  in  32  M0 address
- m0_wdata  in  32  M0 write data
- m0_wstrb  in  4  M0 byte strobes; 0 means read
- m0_rdata  out  32  read data to M0
- m0_ready  out  1  transfer-complete pulse to M0
- m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb  in  1/1/32/32/4  M1 request, same meanings as M0
- m1_rdata  out  32  read data to M1
- m1_ready  out  1  transfer-complete pulse to M1
- mem_valid  out  1  request to downstream bus
- mem_instr  out  1  forwarded instruction flag
- mem_addr  out  32  forwarded address
- mem_wdata  out  32  forwarded write data
- mem_wstrb  out  4  forwarded byte strobes
- mem_rdata  in  32  downstream read data
- mem_ready  in  1  downstream ready
- grant  out  2  one-hot current owner: bit0 = M0, bit1 = M1; 00 = idle
- timeout_err  out  1  sticky timeout flag; present only when ARB_TIMEOUT_EN is defined

Behaviour:
- State register values: IDLE, GNT0, GNT1. Last-winner pointer `last` is 1 bit.
- Reset (resetn low at clk edge):
  - state = IDLE, last = 1, so M0 wins the first contention.
  - grant = 00; timeout_err = 0; counter = 0.
  - mem_valid = 0; mem_instr = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0.
  - m0_ready = 0, m1_ready = 0; m0_rdata = 0, m1_rdata = 0.
- Reset mid-transfer: abandon the transfer immediately. No ready is issued to either master. The downstream bus sees mem_valid drop on the next cycle.
- IDLE:
  - Only m0_valid high -> GNT0.
  - Only m1_valid high -> GNT1.
  - Both high -> grant the master that is not `last`.
  - Neither high -> stay in IDLE.
  - The decision is registered: one cycle of arbitration latency from valid to mem_valid.
- GNT0 / GNT1:
  - mem_* outputs are a combinational mux of the granted master's inputs.
  - mem_valid = granted master's valid.
  - grant reflects the state.
- Completion:
  - When mem_ready = 1, route it combinationally to the granted master's ready, in the same cycle.
  - Route mem_rdata to the granted master's rdata in that same cycle.
  - Set last = granted index; next state = IDLE.
- The non-granted master always sees ready = 0 and rdata = 0.
- Every transfer returns through IDLE, so back-to-back transfers from one master cost 1 idle cycle each.
- The waiting master is guaranteed service after at most one transfer by the other master (round-robin).
- Granted master drops valid before ready: return to IDLE next cycle, no ready pulse, `last` unchanged.
- mem_ready = 1 while in IDLE: ignored.
- Masters must hold addr/wdata/wstrb/instr stable while valid is high (bus protocol). The arbiter does not latch them.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter clears on entry to GNT0/GNT1 and increments each granted cycle with mem_ready low.
  - When the count reaches TIMEOUT_CYCLES, the arbiter forces the granted master's ready = 1 with rdata = ERR_RDATA for one cycle.
  - In that cycle, mem_valid is forced to 0.
  - timeout_err is set to 1 and remains set until reset.
  - State goes to IDLE and `last` updates exactly as on normal completion.
- When undefined: no counter, no timeout_err port, and a stalled slave holds the grant indefinitely.

Test Plan:
- Single-master read: after reset, M0 reads addr 32'h00000100; slave returns ready with rdata 32'h12345678 two cycles after mem_valid -> mem_valid rises 1 cycle after m0_valid; m0_ready pulses once with m0_rdata = 32'h12345678; m1_ready stays 0; grant returns to 00.
- Contention: m0_valid and m1_valid rise together, slave zero-wait -> grant order M0, M1, M0, M1 over four transfers; each transfer separated by one IDLE cycle.
- Write forwarding: M1 writes 32'hA5A5A5A5 with wstrb 4'b0011 to 32'hFFFF0040 -> mem_addr, mem_wdata and mem_wstrb match exactly while grant = 10; m1_ready pulses on the cycle mem_ready is high.
- Reset mid-op: assert resetn low while in GNT1 before mem_ready -> next cycle mem_valid = 0, grant = 00, no m1_ready pulse; first contention after release goes to M0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): M0 read to a slave that never readies -> 8 cycles after grant, m0_ready = 1 with m0_rdata = 32'hDEADBEEF; timeout_err = 1 and stays high; a subsequent M1 request is then granted normally.
